// File: rtl/ss_scan_driver.sv
// Scan driver for an 8-digit seven-segment display: digit select, hex decode and anode gating.
// Latency: seg/dp_n are registered 1 cycle after digit_in; an is registered and aligned with cnt/sel.
// No backpressure: free-running slot counter, inputs are sampled every cycle and may change any time.
module ss_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic [7:0] digit_en,
    input  logic [7:0] dp_in,
    input  logic       lamp_test,
    output logic [2:0] sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp_n
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_sel;
    logic [2:0]       w_sel_nxt;
    logic             w_wrap;
    logic [7:0]       r_an;
    logic [7:0]       w_an_nxt;
    logic [6:0]       r_seg;
    logic [6:0]       w_seg_dec;
    logic             r_dp_n;

    // Next slot position and phase; the anode pattern is computed from the
    // next cnt/sel so the registered an lines up exactly with cnt/sel.
    always_comb begin
        w_wrap      = 1'b0;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_sel_nxt   = r_sel;
        w_state_nxt = ST_SHOW;
        w_an_nxt    = 8'hFF;
        if (r_cnt == CNT_MAX) begin
            w_wrap    = 1'b1;
            w_cnt_nxt = '0;
            w_sel_nxt = r_sel + 3'd1;
        end
        if (w_cnt_nxt < BLANK_END) begin
            w_state_nxt = ST_BLANK;
        end
        if (w_state_nxt == ST_SHOW && digit_en[w_sel_nxt]) begin
            w_an_nxt = ~(8'b1 << w_sel_nxt);
        end
    end

    // Hex to active-low segments {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg_dec = 7'h7F;
        case (digit_in)
            4'h0: w_seg_dec = 7'b1000000;
            4'h1: w_seg_dec = 7'b1111001;
            4'h2: w_seg_dec = 7'b0100100;
            4'h3: w_seg_dec = 7'b0110000;
            4'h4: w_seg_dec = 7'b0011001;
            4'h5: w_seg_dec = 7'b0010010;
            4'h6: w_seg_dec = 7'b0000010;
            4'h7: w_seg_dec = 7'b1111000;
            4'h8: w_seg_dec = 7'b0000000;
            4'h9: w_seg_dec = 7'b0010000;
            4'hA: w_seg_dec = 7'b0001000;
            4'hB: w_seg_dec = 7'b0000011;
            4'hC: w_seg_dec = 7'b1000110;
            4'hD: w_seg_dec = 7'b0100001;
            4'hE: w_seg_dec = 7'b0000110;
            4'hF: w_seg_dec = 7'b0001110;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    // Slot counter, digit select, phase and anode registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sel   <= 3'd0;
            r_state <= ST_BLANK;
            r_an    <= 8'hFF;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_state <= w_state_nxt;
            r_an    <= w_an_nxt;
        end
    end

    // Segment/dp pipeline stage; the 1-cycle lag behind sel falls inside BLANK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg  <= 7'h7F;
            r_dp_n <= 1'b1;
        end else if (lamp_test) begin
            r_seg  <= 7'h00;
            r_dp_n <= 1'b0;
        end else begin
            r_seg  <= w_seg_dec;
            r_dp_n <= ~dp_in[r_sel];
        end
    end

    assign sel  = r_sel;
    assign an   = r_an;
    assign seg  = r_seg;
    assign dp_n = r_dp_n;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Bench for ss_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2 and a table-driven digit mux.
// Expected outputs come from a time-based model: cycle k after reset release is slot (k/8)%8, offset k%8.
// Inputs are changed 1 time unit after the rising edge and outputs sampled there as well.
module tb_ss_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    localparam logic [6:0] DEC [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       clk;
    logic       rst;
    logic [3:0] digit_in;
    logic [7:0] digit_en;
    logic [7:0] dp_in;
    logic       lamp_test;
    logic [2:0] sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp_n;

    logic [3:0] mux_tbl [8];

    int checks;
    int errors;
    int k;

    logic [7:0] e_an;
    logic [2:0] e_sel;
    logic [6:0] e_seg;
    logic       e_dpn;

    ss_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .digit_en  (digit_en),
        .dp_in     (dp_in),
        .lamp_test (lamp_test),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp_n      (dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb digit_in = mux_tbl[sel];

    // At most one anode may ever be low.
    always @(negedge clk) begin
        checks++;
        if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot an=%h (more than one low)", an);
        end
    end

    // Advance one clock with the currently applied inputs and compute what the
    // display must show at cycle k from the slot arithmetic.
    task automatic cycle();
        logic [7:0] a_en;
        logic [7:0] a_dp;
        logic       a_lamp;
        logic [3:0] a_tbl [8];
        int         prev_slot;
        int         slot;
        int         off;
        a_en   = digit_en;
        a_dp   = dp_in;
        a_lamp = lamp_test;
        for (int i = 0; i < 8; i++) a_tbl[i] = mux_tbl[i];
        @(posedge clk);
        #1;
        k++;
        prev_slot = ((k - 1) / RD) % 8;
        slot      = (k / RD) % 8;
        off       = k % RD;
        e_sel = 3'(slot);
        e_an  = (off >= BC && a_en[slot]) ? ~(8'b1 << slot) : 8'hFF;
        e_seg = a_lamp ? 7'h00 : DEC[a_tbl[prev_slot]];
        e_dpn = a_lamp ? 1'b0 : ~a_dp[prev_slot];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp_n !== 1'b1 || sel !== 3'd0) begin
            errors++;
            $display("FAIL reset an=%h seg=%h dp_n=%b sel=%0d, want FF 7F 1 0", an, seg, dp_n, sel);
        end
        rst = 1'b0;
        k = 0;
        cycle();
        checks++;
        if (an !== 8'hFF) begin
            errors++;
            $display("FAIL reset_blank1 an=%h want FF", an);
        end
        cycle();
        checks++;
        if (an !== 8'hFE) begin
            errors++;
            $display("FAIL reset_first_on an=%h want FE", an);
        end
    endtask

    task automatic test_full_frame();
        digit_en = 8'hFF; dp_in = 8'h00; lamp_test = 1'b0;
        while (k % 64 != 0) cycle();
        for (int i = 0; i < 64; i++) begin
            cycle();
            checks++;
            if (an !== e_an || sel !== e_sel || seg !== e_seg || dp_n !== e_dpn) begin
                errors++;
                $display("FAIL frame k=%0d got an=%h sel=%0d seg=%b dp_n=%b want %h %0d %b %b",
                         k, an, sel, seg, dp_n, e_an, e_sel, e_seg, e_dpn);
            end
            if (k % 64 == 2) begin
                checks++;
                if (seg !== 7'b0110000) begin
                    errors++;
                    $display("FAIL slot0_digit3 seg=%b want 0110000", seg);
                end
            end
            if (k % 64 == 58) begin
                checks++;
                if (seg !== 7'b0001000) begin
                    errors++;
                    $display("FAIL slot7_digitA seg=%b want 0001000", seg);
                end
            end
        end
    endtask

    task automatic test_digit_en();
        int lit;
        int start_k;
        lit = 0;
        digit_en = 8'b0000_0101;
        cycle();
        while (k % 64 != 0) cycle();
        start_k = k;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (an != 8'hFF) lit++;
            checks++;
            if (an !== e_an) begin
                errors++;
                $display("FAIL digit_en k=%0d an=%h want %h", k, an, e_an);
            end
        end
        checks++;
        if (lit != 12 || sel !== 3'd0 || k - start_k != 64) begin
            errors++;
            $display("FAIL digit_en_frame lit=%0d sel=%0d want 12 cycles lit and sel 0", lit, sel);
        end
        digit_en = 8'hFF;
    endtask

    task automatic test_dp();
        dp_in = 8'h80;
        for (int i = 0; i < 64; i++) begin
            cycle();
            checks++;
            if (dp_n !== e_dpn || seg !== e_seg) begin
                errors++;
                $display("FAIL dp k=%0d dp_n=%b seg=%b want %b %b", k, dp_n, seg, e_dpn, e_seg);
            end
            if (k % 64 == 60) begin
                checks++;
                if (dp_n !== 1'b0) begin
                    errors++;
                    $display("FAIL dp_slot7 dp_n=%b want 0", dp_n);
                end
            end
        end
        dp_in = 8'h00;
    endtask

    task automatic test_lamp();
        digit_en = 8'b1010_1010;
        lamp_test = 1'b1;
        for (int i = 0; i < 24; i++) begin
            cycle();
            checks++;
            if (seg !== 7'h00 || dp_n !== 1'b0 || an !== e_an) begin
                errors++;
                $display("FAIL lamp k=%0d seg=%h dp_n=%b an=%h want 00 0 %h", k, seg, dp_n, an, e_an);
            end
        end
        lamp_test = 1'b0;
        cycle();
        checks++;
        if (seg !== e_seg || dp_n !== 1'b1) begin
            errors++;
            $display("FAIL lamp_off seg=%b dp_n=%b want %b 1", seg, dp_n, e_seg);
        end
        digit_en = 8'hFF;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 5 == 0) digit_en = 8'($urandom);
            if (i % 7 == 0) dp_in = 8'($urandom);
            lamp_test = ($urandom_range(0, 9) == 0);
            if (i % 3 == 0) mux_tbl[$urandom_range(0, 7)] = 4'($urandom);
            cycle();
            checks++;
            if (an !== e_an || sel !== e_sel || seg !== e_seg || dp_n !== e_dpn) begin
                errors++;
                $display("FAIL random k=%0d got an=%h sel=%0d seg=%b dp_n=%b want %h %0d %b %b",
                         k, an, sel, seg, dp_n, e_an, e_sel, e_seg, e_dpn);
            end
        end
        lamp_test = 1'b0;
        digit_en = 8'hFF;
        dp_in = 8'h00;
        for (int i = 0; i < 8; i++) mux_tbl[i] = 4'(i + 3);
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (k % 64 != 37 && guard < 200) begin
            cycle();
            guard++;
        end
        checks++;
        if (sel !== 3'd4 || an !== 8'hEF) begin
            errors++;
            $display("FAIL mid_reset_setup sel=%0d an=%h want 4 EF", sel, an);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 8'hFF || sel !== 3'd0 || seg !== 7'h7F || dp_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset an=%h sel=%0d seg=%h dp_n=%b want FF 0 7F 1", an, sel, seg, dp_n);
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (an !== e_an || sel !== e_sel || seg !== e_seg || dp_n !== e_dpn) begin
                errors++;
                $display("FAIL after_reset k=%0d an=%h sel=%0d seg=%b want %h %0d %b",
                         k, an, sel, seg, e_an, e_sel, e_seg);
            end
        end
    endtask

    task automatic test_reset_at_wrap();
        int guard;
        guard = 0;
        while (k % 8 != 7 && guard < 20) begin
            cycle();
            guard++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sel !== 3'd0 || an !== 8'hFF) begin
            errors++;
            $display("FAIL reset_at_wrap sel=%0d an=%h want 0 FF", sel, an);
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++;
            if (an !== e_an || sel !== e_sel || seg !== e_seg || dp_n !== e_dpn) begin
                errors++;
                $display("FAIL wrap_resume k=%0d an=%h sel=%0d want %h %0d", k, an, sel, e_an, e_sel);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        k = 0;
        rst = 1'b1;
        digit_en = 8'hFF;
        dp_in = 8'h00;
        lamp_test = 1'b0;
        for (int i = 0; i < 8; i++) mux_tbl[i] = 4'(i + 3);
        test_reset();
        test_full_frame();
        test_digit_en();
        test_dp();
        test_lamp();
        test_random();
        test_mid_reset();
        test_reset_at_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_scan_driver.md
# ss_scan_driver

Time-multiplexed scan driver for the 8-digit seven-segment display. It generates the 3-bit digit select that drives the 8:1 digit mux and takes back the selected 4-bit nibble. It decodes the nibble to active-low segment patterns and drives one-hot active-low anodes. A blanking gap at every digit change suppresses ghosting.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (100 MHz gives 1 kHz per digit, 125 Hz frame). Legal range 4..2^20.
- `BLANK_CYCLES`, default 16: cycles at the start of each slot with all anodes off. Legal range 2..REFRESH_DIV-2.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `digit_in` input 4: nibble returned by the digit mux for the current `sel`. Combinational from `sel`.
- `digit_en` input 8: per-digit enable. Bit i=0 keeps anode i off for its whole slot.
- `dp_in` input 8: per-digit decimal point, active-high.
- `lamp_test` input 1: while 1, every enabled digit shows all segments and the dp lit.
- `sel` output 3: digit index to the mux.
- `an` output 8: anodes, active-low, one-hot-low or all high.
- `seg` output 7: segments {g,f,e,d,c,b,a}, bit 6..0, active-low.
- `dp_n` output 1: decimal point, active-low.

## Operation
- Slot counter `cnt` runs 0..REFRESH_DIV-1 and wraps.
- When `cnt` = REFRESH_DIV-1, `sel` advances on the next edge: `sel` <= `sel`+1, with 7 wrapping to 0. `cnt` returns to 0 on the same edge.
- Slot phases, expressed as a state machine over `cnt`:
  - BLANK, `cnt` < BLANK_CYCLES: `an` = 8'hFF.
  - SHOW, `cnt` >= BLANK_CYCLES: `an` = ~(1<<`sel`) if `digit_en`[`sel`], otherwise 8'hFF.
- `seg` and `dp_n` are registered every cycle from the current `digit_in`/`dp_in`[`sel`]. They lag `sel` by 1 cycle, and this lag is hidden inside BLANK.
- Hex decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- `lamp_test`=1 overrides decode: `seg`=7'h00, `dp_n`=0. Anode gating by `digit_en` and BLANK is unchanged.
- Disabled digits still consume their slot, so brightness stays independent of the number of enabled digits.
- `digit_en`, `dp_in` and `lamp_test` may change at any time. They take effect on the next registered update and need no resynchronisation.
- `an` is registered and is a function of the registered `cnt`/`sel`.

## Timing
- Reset values: `cnt`=0, `sel`=0, `an`=8'hFF, `seg`=7'h7F, `dp_n`=1.
- `rst` asserted mid-slot returns all outputs to reset values on the next edge. The first slot after reset release begins at `cnt`=0, `sel`=0, in BLANK.
- `an` changes exactly at the first edge where `cnt` = BLANK_CYCLES (on) and at the `cnt` wrap edge (off). No anode is ever low while `sel` or `seg` is changing.
- Never more than one `an` bit low at any time.
- `seg` latency is 1 cycle from `digit_in`. A change of `digit_in` within SHOW appears on `seg` 1 cycle later.
- Full frame = 8×REFRESH_DIV cycles. `sel` sequence is 0,1,…,7,0 with no skips.
- Reset asserted together with the `cnt` wrap: reset wins and `sel`=0.

## Test plan
Bench parameters: REFRESH_DIV=8, BLANK_CYCLES=2, model mux returning `sel`+3.
- Reset: hold `rst` 3 cycles, then release → `an`=FF, `seg`=7F, `dp_n`=1, `sel`=0. First `an`=FE appears at cycle 2 after release.
- Full frame, `digit_en`=FF, `dp_in`=0 → `sel` steps 0..7 every 8 cycles.
  - `an` pattern per slot: FF,FF, then 6 cycles of ~(1<<`sel`).
  - Slot 0 shows `seg`=0110000 (3). Slot 7 shows `seg`=0001000 (A).
- `digit_en`=8'b0000_0101 → `an` low only in slots 0 and 2. Frame length stays 64 cycles.
- `dp_in`=8'h80 → `dp_n`=0 only during slot 7 SHOW (from 1 cycle after `sel`=7), 1 elsewhere.
- `lamp_test`=1 → `seg`=00 and `dp_n`=0 on every enabled slot, with BLANK still all-FF. Deassert it → normal decode on the next cycle.
- Mid-slot reset at `cnt`=5, `sel`=4 → next edge `an`=FF, `sel`=0. Assert throughout that at most one `an` bit is low.
